// File: rtl/div_seq.sv
// div_seq: iterative restoring divider for the DIV/DIVU path (q -> LO, r -> HI).
// Optional macro DIV_DZ_FLAG_EN adds the dz output and a one-cycle divide-by-zero path.
module div_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic             sign,
   input  logic             cancel,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             ready
`ifdef DIV_DZ_FLAG_EN
   ,
   output logic             dz
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIN
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_zero;
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   r_r;
   logic               r_busy;
   logic               r_ready;

   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic               w_ge;
   logic [WIDTH-1:0]   w_rem_nx;
   logic [WIDTH-1:0]   w_quo_nx;
   logic [WIDTH-1:0]   w_q_fin;
   logic [WIDTH-1:0]   w_r_fin;
   logic               w_accept;
   logic               w_last;
   logic               w_dz_in;

   // Operand magnitudes; -2^(WIDTH-1) maps to unsigned 2^(WIDTH-1)
   assign w_a_neg = sign & dividend[WIDTH-1];
   assign w_b_neg = sign & divisor[WIDTH-1];
   assign w_abs_a = w_a_neg ? -dividend : dividend;
   assign w_abs_b = w_b_neg ? -divisor : divisor;
   assign w_dz_in = (divisor == '0);

   // One restoring step: shift {rem,quo} left, trial-subtract on WIDTH+1 bits
   assign w_shift  = {r_rem, r_quo[WIDTH-1]};
   assign w_diff   = w_shift - {1'b0, r_div};
   assign w_ge     = ~w_diff[WIDTH];
   assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

   // Sign correction: q negated on differing signs, r follows dividend sign
   assign w_q_fin = r_zero  ? '1 :
                    r_neg_q ? -w_quo_nx : w_quo_nx;
   assign w_r_fin = r_neg_r ? -w_rem_nx : w_rem_nx;

   assign w_accept = start & ~cancel & (r_state != S_RUN);
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   assign q     = r_q;
   assign r     = r_r;
   assign busy  = r_busy;
   assign ready = r_ready;

`ifdef DIV_DZ_FLAG_EN
   logic r_dz;
   assign dz = r_dz;

   // Divide-by-zero flag, refreshed by every accepted start
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_dz <= 1'b0;
      end else if (w_accept) begin
         r_dz <= w_dz_in;
      end
   end
`endif

   // Control FSM and datapath registers; results written only on completion
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_div   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_zero  <= 1'b0;
         r_q     <= '0;
         r_r     <= '0;
         r_busy  <= 1'b0;
         r_ready <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            S_RUN: begin
               if (cancel) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_rem <= w_rem_nx;
                  r_quo <= w_quo_nx;
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) begin
                     r_state <= S_FIN;
                     r_busy  <= 1'b0;
                     r_ready <= 1'b1;
                     r_q     <= w_q_fin;
                     r_r     <= w_r_fin;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               if (w_accept) begin
                  r_rem   <= '0;
                  r_quo   <= w_abs_a;
                  r_div   <= w_abs_b;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  r_zero  <= w_dz_in;
                  r_cnt   <= '0;
`ifdef DIV_DZ_FLAG_EN
                  if (w_dz_in) begin
                     r_state <= S_FIN;
                     r_ready <= 1'b1;
                     r_q     <= '1;
                     r_r     <= dividend;
                  end else begin
                     r_state <= S_RUN;
                     r_busy  <= 1'b1;
                  end
`else
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
`endif
               end
            end
         endcase
      end
   end

endmodule
